// File: rtl/rv_m_pkg.sv
// Shared RV32M definitions used by the multiply/divide sequencer.
// Contents:
//   - Decode match constants for the OP opcode with the M-extension funct7.
//   - funct3 encodings for the eight M-extension operations.
//   - The FSM state encoding.
//   - Helpers that report which operands are signed for a given funct3.
package rv_m_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned CNT_W_DEF = 6;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] F7_MULDIV  = 7'b0000001;

   localparam logic [2:0] F3_MUL    = 3'b000;
   localparam logic [2:0] F3_MULH   = 3'b001;
   localparam logic [2:0] F3_MULHSU = 3'b010;
   localparam logic [2:0] F3_MULHU  = 3'b011;
   localparam logic [2:0] F3_DIV    = 3'b100;
   localparam logic [2:0] F3_DIVU   = 3'b101;
   localparam logic [2:0] F3_REM    = 3'b110;
   localparam logic [2:0] F3_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   // MUL only keeps the low half, which is identical signed or unsigned.
   function automatic logic signed_a(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   function automatic logic signed_b(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
   endfunction

   // A high-half multiply, or a remainder, is taken from the upper result word.
   function automatic logic sel_high(input logic [2:0] f3);
      return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU) ||
             (f3 == F3_REM) || (f3 == F3_REMU);
   endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negate of a pair of words.
// The pair is handled in one of two modes:
//   - Independent (link_i=0): each word is negated on its own flag. This mode
//     produces the operand magnitudes and the quotient/remainder signs.
//   - Linked (link_i=1): {hi,lo} is treated as one 2W-bit value and negated
//     on neg_lo_i. This mode fixes the sign of a full product.
// Ports:
//   lo_i, hi_i          : input words
//   neg_lo_i, neg_hi_i  : negate flags
//   link_i              : select linked mode
//   lo_o, hi_o          : corrected words
module mdu_sign_fix #(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0] lo_i,
   input  logic [W-1:0] hi_i,
   input  logic         neg_lo_i,
   input  logic         neg_hi_i,
   input  logic         link_i,
   output logic [W-1:0] lo_o,
   output logic [W-1:0] hi_o
);

   logic [2*W-1:0] wide_neg;

   assign wide_neg = (2*W)'(0) - {hi_i, lo_i};

   always_comb begin
      lo_o = lo_i;
      hi_o = hi_i;
      if (link_i) begin
         if (neg_lo_i) {hi_o, lo_o} = wide_neg;
      end else begin
         if (neg_lo_i) lo_o = W'(0) - lo_i;
         if (neg_hi_i) hi_o = W'(0) - hi_i;
      end
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit that runs beside the ALU in EX.
// It works on operand magnitudes, one bit per cycle:
//   - Multiply uses a shift-add step.
//   - Divide uses a restoring step.
// A final sign-fix cycle restores the signs. Divide by zero and the signed
// overflow case bypass the iteration and complete one cycle after start.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : valid M-extension instruction in EX
//   funct3, rs1, rs2    : operation select and operands, sampled with start
//   flush               : abort the EX instruction
//   stall               : combinational pipeline hold request
//   done                : one-cycle result valid
//   result              : result word, zero unless done
module mdu_sequencer
   import rv_m_pkg::*;
#(
   parameter int unsigned XLEN  = XLEN_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            stall,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   mdu_state_e        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        f3_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   opb_q;
   logic [XLEN-1:0]   res_q;
   logic              neg_q;
   logic              negr_q;

   logic            neg_a, neg_b;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            div_zero, div_ovf;
   logic [XLEN-1:0] spec_res;
   logic [XLEN-1:0] fix_lo, fix_hi;

   // Operand magnitudes
   assign neg_a = signed_a(funct3) & rs1[XLEN-1];
   assign neg_b = signed_b(funct3) & rs2[XLEN-1];

   mdu_sign_fix #(.W(XLEN)) u_in_fix (
      .lo_i     (rs1),
      .hi_i     (rs2),
      .neg_lo_i (neg_a),
      .neg_hi_i (neg_b),
      .link_i   (1'b0),
      .lo_o     (mag_a),
      .hi_o     (mag_b)
   );

   // Divide special cases, resolved directly from the raw operands
   assign div_zero = funct3[2] & (rs2 == '0);
   assign div_ovf  = funct3[2] & ~funct3[0] & (rs1 == INT_MIN) & (rs2 == '1);
   always_comb begin
      spec_res = '0;
      if (div_zero)     spec_res = funct3[1] ? rs1 : '1;
      else if (div_ovf) spec_res = funct3[1] ? '0  : INT_MIN;
   end

   // Shift-add multiply step: add into the high half, then shift the whole register right
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

   // Restoring divide step: high half is the partial remainder, low half shifts in quotient bits
   logic [XLEN:0]     div_rem_sh;
   logic              div_ge;
   logic [XLEN-1:0]   div_sub;
   logic [2*XLEN-1:0] div_next;
   assign div_rem_sh = acc_q[2*XLEN-1:XLEN-1];
   assign div_ge     = div_rem_sh >= {1'b0, opb_q};
   assign div_sub    = XLEN'(div_rem_sh - {1'b0, opb_q});
   assign div_next   = div_ge ? {div_sub, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};

   // Final sign correction: the full product is negated as one value, quotient and remainder separately
   mdu_sign_fix #(.W(XLEN)) u_out_fix (
      .lo_i     (acc_q[XLEN-1:0]),
      .hi_i     (acc_q[2*XLEN-1:XLEN]),
      .neg_lo_i (neg_q),
      .neg_hi_i (negr_q),
      .link_i   (~f3_q[2]),
      .lo_o     (fix_lo),
      .hi_o     (fix_hi)
   );

   // Sequencing FSM and iteration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         f3_q    <= '0;
         acc_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         neg_q   <= 1'b0;
         negr_q  <= 1'b0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  f3_q   <= funct3;
                  opb_q  <= mag_b;
                  acc_q  <= {{XLEN{1'b0}}, mag_a};
                  neg_q  <= neg_a ^ neg_b;
                  negr_q <= neg_a;
                  if (div_zero | div_ovf) begin
                     res_q   <= spec_res;
                     cnt_q   <= '0;
                     state_q <= ST_DONE;
                  end else begin
                     cnt_q   <= CNT_W'(XLEN);
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               acc_q <= f3_q[2] ? div_next : mul_next;
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) state_q <= ST_FIX;
            end
            ST_FIX: begin
               res_q   <= sel_high(f3_q) ? fix_hi : fix_lo;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               res_q   <= '0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // A flush in the result cycle kills the done pulse as well as the hold request
   assign done   = (state_q == ST_DONE) & ~flush;
   assign result = done ? res_q : '0;
   assign stall  = ~flush & (((state_q == ST_IDLE) & start) |
                             (state_q == ST_CALC) | (state_q == ST_FIX));

endmodule

// File: tb/tb_mdu_sequencer.sv
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1, rs2;
   logic        flush;
   logic        stall, done;
   logic [31:0] result;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mdu_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .funct3 (funct3),
      .rs1    (rs1),
      .rs2    (rs2),
      .flush  (flush),
      .stall  (stall),
      .done   (done),
      .result (result)
   );

   // RV32M result computed with plain 64-bit arithmetic
   function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, ua, ub, p;
      logic [63:0] pu;
      int          ia, ib;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      ia = $signed(a);
      ib = $signed(b);
      case (f3)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * ub; return p[63:32]; end
         3'd3: begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(ia / ib);
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return 32'(ia % ib);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete operation from the start cycle T through the cycle after done
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int          lat;
      int          n;
      logic        spec;
      exp  = ref_m(f3, a, b);
      spec = f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
      lat  = spec ? 1 : 34;
      start = 1'b1; funct3 = f3; rs1 = a; rs2 = b;
      #1;
      chk("stall_accept", 32'(stall), 1);
      chk("done_idle", 32'(done), 0);
      step();
      start = 1'b0; rs1 = $urandom; rs2 = $urandom; funct3 = 3'($urandom);
      #1;
      n = 1;
      while (done !== 1'b1 && n < 40) begin
         chk("stall_busy", 32'(stall), 1);
         chk("result_busy", result, 0);
         step();
         start = 1'($urandom_range(0, 1));
         #1;
         n++;
      end
      chk("latency", 32'(n), 32'(lat));
      chk("done", 32'(done), 1);
      chk("result", result, exp);
      start = 1'b1;
      #1;
      chk("stall_done", 32'(stall), 0);
      step();
      start = 1'b0;
      #1;
      chk("done_clear", 32'(done), 0);
      chk("result_clear", result, 0);
      chk("stall_idle", 32'(stall), 0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: return 32'h0;
         2: return 32'h8000_0000;
         3: return 32'hFFFF_FFFF;
         4: return 32'($urandom_range(0, 20));
         default: return 32'h0 - 32'($urandom_range(1, 20));
      endcase
   endfunction

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
      repeat (3) step();
      chk("rst_done", 32'(done), 0);
      chk("rst_result", result, 0);
      chk("rst_stall", 32'(stall), 0);
      rst = 1'b0;
      step();

      // Directed operations
      do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000);
      do_op(3'd3, 32'h8000_0000, 32'h8000_0000);
      do_op(3'd2, 32'hFFFF_FFFF, 32'd2);
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
      do_op(3'd5, 32'd100, 32'd0);
      do_op(3'd7, 32'd100, 32'd0);
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2);

      // Flush takes priority over start in IDLE
      start = 1'b1; flush = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd5;
      #1;
      chk("flush_prio_stall", 32'(stall), 0);
      step();
      start = 1'b0; flush = 1'b0;
      #1;
      chk("flush_prio_idle", 32'(stall), 0);
      chk("flush_prio_done", 32'(done), 0);
      step();

      // Flush at T+10 of a DIVU, then a MUL accepted at T+11
      start = 1'b1; funct3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd7;
      #1;
      chk("flush_op_stall", 32'(stall), 1);
      step();
      start = 1'b0;
      repeat (9) step();
      flush = 1'b1;
      #1;
      chk("flush_stall", 32'(stall), 0);
      chk("flush_done", 32'(done), 0);
      chk("flush_result", result, 0);
      step();
      flush = 1'b0;
      do_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF0);

      // Reset at T+20 of a MUL, with start held during reset
      start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
      step();
      start = 1'b0;
      repeat (19) step();
      rst = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      #1;
      chk("rst_mid_done", 32'(done), 0);
      chk("rst_mid_result", result, 0);
      chk("rst_mid_stall", 32'(stall), 0);
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         chk("rst_quiet_done", 32'(done), 0);
         chk("rst_quiet_stall", 32'(stall), 0);
      end

      // Randomized operations against the reference
      for (int i = 0; i < 150; i++) begin
         do_op(3'($urandom), pick(), pick());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its own sequencing FSM; sits in EX beside the ALU.
- Triggered when the control unit decodes OP (0110011) with funct7 = 0000001.
- Holds the pipeline through a stall output while it iterates, then presents one result for one cycle so EX can advance.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
CNT_W, 6, iteration counter width (must hold XLEN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  EX holds a valid M-extension instruction this cycle
funct3  input  3  M-op select, sampled with start
rs1  input  XLEN  operand A, sampled with start
rs2  input  XLEN  operand B, sampled with start
flush  input  1  pipeline flush of the EX instruction; aborts any operation
stall  output  1  combinational hold request to the hazard unit
done  output  1  result valid pulse, one cycle
result  output  XLEN  selected result, valid only while done=1

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset:
  - state=IDLE, counter=0, internal registers 0.
  - done=0, result=0, stall=0.
  - A reset mid-operation discards the operation; no done is produced.
- funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE:
  - start=1 and flush=0 at cycle T: latch funct3 and the operand magnitudes (absolute values for signed operands), record the result sign, clear the accumulator.
  - Normal case -> CALC with counter=XLEN.
  - Divide with rs2=0, or DIV/REM with rs1=0x80000000 and rs2=0xFFFFFFFF -> DONE directly (special case).
- CALC:
  - One iteration per cycle; counter decrements.
  - Multiply: conditional add of the multiplicand, then shift right of the 2*XLEN product register.
  - Divide: shift left, trial subtract, restore on negative.
  - After the last iteration (counter reaches 0 after 32 cycles) -> FIX.
- FIX: apply the sign correction (two's complement negate) and select the result half or quotient/remainder -> DONE.
- DONE: done=1, result driven -> IDLE next cycle unconditionally.
- Latency: normal ops have done=1 in cycle T+34; special divides have done=1 in cycle T+1.
- Stall:
  - stall = (IDLE & start & ~flush) | CALC | FIX.
  - stall=0 in DONE, so the instruction leaves EX in the same cycle that result is valid.
- Result rules:
  - MUL: low 32 bits of the product.
  - MULH: high 32 bits, signed×signed. MULHSU: high 32 bits, signed×unsigned. MULHU: high 32 bits, unsigned×unsigned.
  - Divide by zero: quotient=0xFFFFFFFF (DIV and DIVU), remainder=rs1.
  - Signed overflow: quotient=0x80000000, remainder=0.
  - Signed remainder takes the sign of the dividend; quotient truncates toward zero.
- flush=1 in any state:
  - Next state IDLE; done is suppressed in that cycle and afterwards.
  - stall is forced to 0 combinationally in the flush cycle.
  - flush has priority over start.
- start while the FSM is not in IDLE is ignored; the instruction is held anyway by stall.
- start in the DONE cycle is ignored; the next instruction's start is accepted from IDLE one cycle later.
- result is 0 whenever done=0.

Decomposition:
- Shared package rv_m_pkg:
  - funct3 constants (F3_MUL .. F3_REMU), OP/funct7 match constants.
  - FSM state encoding (2-bit: IDLE=0, CALC=1, FIX=2, DONE=3).
  - XLEN default.
- One sub-module: mdu_sign_fix, combinational.
  - Computes operand magnitudes and signs per funct3.
  - Performs the final conditional negate.
  - Instantiated once at the input and once at the output.
- FSM, counter and iteration registers stay in mdu_sequencer.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD, start at T -> stall=1 for T..T+33, done=1 at T+34, result=0xFFFFFFEB; done=0 at T+35.
- MULH rs1=rs2=0x80000000 -> result=0x40000000. MULHU on the same operands -> 0x40000000. MULHSU rs1=0xFFFFFFFF, rs2=2 -> 0xFFFFFFFF.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done at T+1, result=0x80000000; REM on the same operands -> 0 at T+1.
- DIVU rs1=100, rs2=0 -> done at T+1, result=0xFFFFFFFF; REMU rs1=100, rs2=0 -> result=100. REM rs1=0xFFFFFFF9 (−7), rs2=2 -> result=0xFFFFFFFF at T+34; DIV on the same operands -> 0xFFFFFFFD.
- Flush at T+10 of a DIVU -> stall=0 at T+10, no done ever; new MUL start at T+11 accepted, done at T+45.
- rst at T+20 of a MUL -> all outputs 0 next cycle, no done; start ignored while rst=1.
